bitop_arbiter: RTL and testbench
================================

# bitop_arbiter

Two-requester arbiter and sequencer for the shared 16-bit bitwise logic unit (AND/OR/XOR/NOT). The block accepts operation requests from two independent clients and grants them round-robin. It latches the granted operands, runs one operation through the logic unit, and returns the result over a valid/ready response channel tagged with the requester ID. It sits between the instruction-issue logic and the bitwise datapath, so the datapath is never driven by more than one client per operation.

## Interface
- WIDTH, 16, operand/result width in bits
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 request accepted this cycle
- req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NOT
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B (ignored for NOT)
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same widths and meaning, requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes the result
- rsp_data  output  WIDTH  operation result
- rsp_id  output  1  requester that issued the operation
- rsp_op  output  2  opcode that produced rsp_data
- rsp_zero  output  1  rsp_data is all zeros (see Configuration)

## Operation
- FSM states:
  - IDLE: no operation in flight.
  - EXEC: latched operands are driven through the logic unit, and the result is registered at the end of the cycle.
  - HOLD: result is presented on the response channel.
- Transitions:
  - IDLE→EXEC on an accept.
  - EXEC→HOLD unconditionally.
  - HOLD→IDLE on rsp_ready with no new accept.
  - HOLD→EXEC on rsp_ready with a new accept in the same cycle.
- Accept window is open when state==IDLE, or when state==HOLD and rsp_ready==1. No request is accepted in EXEC, or in HOLD while rsp_ready==0.
- Grant rule:
  - Only one requester is valid: it is granted.
  - Both are valid: the requester not granted most recently wins.
  - After reset, requester 0 has priority.
- reqN_ready = window_open & grant[N]. It is combinational and never high for both requesters in the same cycle.
- Accept = reqN_valid & reqN_ready. On accept, the block captures op, a, b and the ID, and the round-robin pointer moves to the other requester. The pointer does not change on cycles without an accept.
- Datapath is purely bitwise:
  - AND: a&b
  - OR: a|b
  - XOR: a^b
  - NOT: ~a
- There is no carry, and no bits cross positions.
- The response registers (rsp_data, rsp_id, rsp_op, rsp_zero) stay stable throughout HOLD until the consumer takes them with rsp_ready.
- rsp_valid==1 exactly when state==HOLD.
- Requesters may deassert valid or change operands at any time before accept. Values captured at accept are the only ones used.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_op=0, rsp_zero=0
  - round-robin pointer favours requester 0
  - any in-flight operation is discarded with no response
- Latency:
  - Accept at cycle N gives EXEC at N+1 and rsp_valid=1 at N+2.
  - The earliest next accept is at cycle N+2, together with the consumer taking the response.
- Throughput: with a consumer that always takes the result, one operation every 2 cycles.
- Back-pressure: while rsp_ready==0 in HOLD, both reqN_ready stay 0 and outputs hold indefinitely.
- Simultaneous valid on both requesters: one grant per accept window, strictly alternating while both remain valid.
- rsp_ready while state is IDLE or EXEC has no effect.
- rst_n deassertion is synchronised externally. The block does not accept in the first cycle it leaves reset unless a requester's valid is already high.

## Configuration
- BITOP_ARB_ZFLAG_EN
  - Defined: rsp_zero is registered in EXEC as (result == 0) and held in HOLD with the other response fields.
  - Undefined: the zero-detect logic is absent and rsp_zero is tied to 0 at all times.
- The port list is identical in both builds.

## Test plan
- Reset with both requesters idle → rsp_valid=0, rsp_data=0, rsp_zero=0, req0_ready=req1_ready=0 (neither requester is valid, so neither is granted).
- req0: op=00, a=16'hF0F0, b=16'hFF00, rsp_ready=1 → req0_ready=1 at N; rsp_valid=1 at N+2 with rsp_data=16'hF000, rsp_id=0, rsp_op=00.
- Both requesters held valid; req0 sends XOR a=16'hAAAA b=16'h5555; req1 sends NOT a=16'h00FF → grants alternate 0,1,0,1. Responses are 16'hFFFF (id 0) then 16'hFF00 (id 1), each 2 cycles apart.
- Response back-pressure:
  - Stimulus: req1 OR a=16'h0000 b=16'h0000, with rsp_ready=0 held for 5 cycles.
  - Response: rsp_valid stays 1 and rsp_data=0 is stable. rsp_zero=1 with BITOP_ARB_ZFLAG_EN defined, 0 without it. req0_ready and req1_ready stay 0 throughout.
  - Release: raising rsp_ready with req0 valid gives HOLD→EXEC in the same cycle.
- Reset mid-operation: assert rst_n=0 during EXEC → rsp_valid never asserts for that operation. After release, req0 wins a simultaneous request ahead of req1.

Source files
------------

// File: rtl/bitop_arbiter.sv
// bitop_arbiter
//   Two-requester round-robin arbiter and sequencer for the shared bitwise
//   logic unit (AND/OR/XOR/NOT). A granted request is latched, run through
//   the logic unit for one cycle, and returned on a valid/ready response
//   channel tagged with the requester ID and opcode.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. Requesters may change or drop valid/op/a/b freely until that
//   edge. reqN_ready is combinational and depends on reqN_valid. rsp_valid
//   is registered, and the rsp_* fields stay stable until rsp_ready is seen.
//
//   Optional build macro: BITOP_ARB_ZFLAG_EN
//     defined   - rsp_zero reports (rsp_data == 0), registered with the result
//     undefined - rsp_zero is tied low (no zero-detect logic)
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   reqN_valid/ready         request handshake, N = 0, 1
//   reqN_op                  00 AND, 01 OR, 10 XOR, 11 NOT
//   reqN_a, reqN_b           operands (b ignored for NOT)
//   rsp_valid/ready          response handshake
//   rsp_data, rsp_id, rsp_op result, issuing requester, opcode
//   rsp_zero                 result-is-zero flag (see macro above)
module bitop_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic [1:0]       rsp_op,
    output logic             rsp_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic             rr_ptr;      // 1: requester 1 wins a tie
    logic [1:0]       lat_op;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;
    logic             lat_id;

    logic             window_open;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             accept_id;
    logic [WIDTH-1:0] result;

    // New work can only enter when nothing is in flight, or when the held
    // response is leaving on this same edge.
    assign window_open = (state == IDLE) || ((state == HOLD) && rsp_ready);

    // A lone valid requester always wins; on a tie the pointer decides.
    assign grant0 = req0_valid && (!req1_valid || !rr_ptr);
    assign grant1 = req1_valid && (!req0_valid || rr_ptr);

    assign req0_ready = window_open && grant0;
    assign req1_ready = window_open && grant1;

    assign accept    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign accept_id = req1_ready;

    always_comb begin
        result = '0;
        case (lat_op)
            2'b00:   result = lat_a & lat_b;
            2'b01:   result = lat_a | lat_b;
            2'b10:   result = lat_a ^ lat_b;
            default: result = ~lat_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            lat_op    <= 2'b00;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_id    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            rsp_op    <= 2'b00;
`ifdef BITOP_ARB_ZFLAG_EN
            rsp_zero  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                lat_op <= accept_id ? req1_op : req0_op;
                lat_a  <= accept_id ? req1_a  : req0_a;
                lat_b  <= accept_id ? req1_b  : req0_b;
                lat_id <= accept_id;
                rr_ptr <= ~accept_id;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= result;
                    rsp_id    <= lat_id;
                    rsp_op    <= lat_op;
                    rsp_valid <= 1'b1;
`ifdef BITOP_ARB_ZFLAG_EN
                    rsp_zero  <= (result == '0);
`endif
                    state     <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifndef BITOP_ARB_ZFLAG_EN
    assign rsp_zero = 1'b0;
`endif

endmodule

// File: tb/tb_bitop_arbiter.sv
// tb_bitop_arbiter
//   Directed scenarios followed by randomized traffic. A reference model
//   derives grants, accept windows and response timing from the block's
//   rules (lone requester wins, ties alternate, result two cycles after
//   accept, held until taken) and pushes expected responses into a queue;
//   a monitor compares every presented response against the queue head.
module tb_bitop_arbiter;

    localparam int WIDTH = 16;
    localparam int EW    = WIDTH + 4;   // {id, op[1:0], zero, data}

    logic             clk;
    logic             rst_n;
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic [1:0]       rsp_op;
    logic             rsp_zero;

    bitop_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_op     (rsp_op),
        .rsp_zero   (rsp_zero)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    function automatic logic [EW-1:0] make_exp(input logic id, input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] d;
        logic z;
        d = ref_op(op, a, b);
`ifdef BITOP_ARB_ZFLAG_EN
        z = (d == '0);
`else
        z = 1'b0;
`endif
        return {id, op, z, d};
    endfunction

    // ---------------- reference model (stimulus side) ----------------
    logic m_busy = 1'b0;        // an operation is in flight or held
    int   m_acc_cyc = 0;        // cycle of the last accept
    logic m_last = 1'b1;        // last granted id; 1 so requester 0 wins first tie

    always @(negedge clk) begin
        logic rsp_due, window, e0, e1;
        if (!rst_n) begin
            exp_q.delete();
            m_busy = 1'b0;
            m_last = 1'b1;
            check("rst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
        end else begin
            rsp_due = m_busy && (cyc >= m_acc_cyc + 2);
            window  = !m_busy || (rsp_due && rsp_ready);
            e0 = 1'b0;
            e1 = 1'b0;
            if (window) begin
                if (req0_valid && (!req1_valid || m_last == 1'b1)) e0 = 1'b1;
                else if (req1_valid)                               e1 = 1'b1;
            end
            check("req0_ready", 32'(req0_ready), 32'(e0));
            check("req1_ready", 32'(req1_ready), 32'(e1));
            check("rsp_valid",  32'(rsp_valid),  32'(rsp_due));
            if (rsp_due && rsp_ready) m_busy = 1'b0;
            if (e0 || e1) begin
                if (e0) exp_q.push_back(make_exp(1'b0, req0_op, req0_a, req0_b));
                else    exp_q.push_back(make_exp(1'b1, req1_op, req1_a, req1_b));
                m_busy    = 1'b1;
                m_acc_cyc = cyc;
                m_last    = e1;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(1'b1), 32'(1'b0));
            end else begin
                e = exp_q[0];
                check("rsp_data", 32'(rsp_data), 32'(e[WIDTH-1:0]));
                check("rsp_zero", 32'(rsp_zero), 32'(e[WIDTH]));
                check("rsp_op",   32'(rsp_op),   32'(e[WIDTH+2:WIDTH+1]));
                check("rsp_id",   32'(rsp_id),   32'(e[WIDTH+3]));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive0(input logic v, input logic [1:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic drive1(input logic v, input logic [1:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        return ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b1;
        rsp_ready = 1'b0;
        drive0(1'b0, 2'b00, '0, '0);
        drive1(1'b0, 2'b00, '0, '0);

        #2 rst_n = 1'b0;
        #2;
        check("reset_rsp_valid",  32'(rsp_valid),  32'(1'b0));
        check("reset_rsp_data",   32'(rsp_data),   32'(16'h0000));
        check("reset_rsp_id",     32'(rsp_id),     32'(1'b0));
        check("reset_rsp_op",     32'(rsp_op),     32'(2'b00));
        check("reset_rsp_zero",   32'(rsp_zero),   32'(1'b0));
        check("reset_req0_ready", 32'(req0_ready), 32'(1'b0));
        check("reset_req1_ready", 32'(req1_ready), 32'(1'b0));
        step(2);
        rst_n = 1'b1;
        step(2);

        // Single AND from requester 0: expect F000, id 0.
        rsp_ready = 1'b1;
        drive0(1'b1, 2'b00, 16'hF0F0, 16'hFF00);
        step(1);
        req0_valid = 1'b0;
        step(4);

        // Both held valid: grants alternate 0,1,0,1.
        drive0(1'b1, 2'b10, 16'hAAAA, 16'h5555);
        drive1(1'b1, 2'b11, 16'h00FF, 16'h1234);
        step(9);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step(3);

        // Back-pressure: zero result held, then released with a new accept.
        rsp_ready = 1'b0;
        drive1(1'b1, 2'b01, 16'h0000, 16'h0000);
        step(1);
        req1_valid = 1'b0;
        drive0(1'b1, 2'b00, 16'h1234, 16'hFFFF);
        step(7);
        rsp_ready = 1'b1;
        step(1);
        req0_valid = 1'b0;
        step(4);

        // Reset during EXEC: in-flight operation is dropped.
        drive0(1'b1, 2'b01, 16'h0F00, 16'h00F0);
        step(1);
        req0_valid = 1'b0;
        rst_n = 1'b0;
        step(2);
        drive0(1'b1, 2'b00, 16'hFFFF, 16'h8001);
        drive1(1'b1, 2'b10, 16'h1111, 16'h2222);
        rst_n = 1'b1;
        step(6);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step(3);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            drive0($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rand_word(), rand_word());
            drive1($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rand_word(), rand_word());
            rsp_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end

        // Drain with a bounded wait.
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
        check("drain_empty", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
